// File: rtl/button_debouncer_if.sv
// Button-side bundle of the debouncer: raw button levels in, conditioned strobes out.
// The game-logic side (or a bench) uses master; the debouncer itself uses slave.
interface button_debouncer_if #(
  parameter int N_BTN = 4
);
  logic [N_BTN-1:0] buttons;
  logic [N_BTN-1:0] DPBs;
  logic [N_BTN-1:0] SCENs;
  logic [N_BTN-1:0] MCENs;
  logic [N_BTN-1:0] CCENs;

  modport master (output buttons, input DPBs, input SCENs, input MCENs, input CCENs);
  modport slave  (input buttons, output DPBs, output SCENs, output MCENs, output CCENs);
endinterface

// File: rtl/button_debouncer.sv
// Per-button 2-FF synchronizer feeding an independent debounce / auto-repeat FSM.
// Outputs are registered decodes of the next state, so no input reaches an output combinationally.
module button_debouncer #(
  parameter int N_BTN           = 4,
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int MCEN_DELAY      = 50_000_000,
  parameter int MCEN_PERIOD     = 10_000_000
) (
  input  logic              clk,
  input  logic              reset_n,
  button_debouncer_if.slave bus
);

  localparam int MAX_AB  = (DEBOUNCE_CYCLES > MCEN_DELAY) ? DEBOUNCE_CYCLES : MCEN_DELAY;
  localparam int MAX_CNT = (MAX_AB > MCEN_PERIOD) ? MAX_AB : MCEN_PERIOD;
  localparam int CNT_W   = $clog2(MAX_CNT);

  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(MCEN_DELAY - 1);
  localparam logic [CNT_W-1:0] PER_LAST = CNT_W'(MCEN_PERIOD - 1);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_PRESS,
    SCEN_ST,
    HOLD,
    MCEN_ST,
    REPEAT,
    WAIT_RELEASE
  } state_t;

  logic [N_BTN-1:0] sync_p0;
  logic [N_BTN-1:0] sync_p1;

  state_t           state_q [N_BTN];
  state_t           state_d [N_BTN];
  logic [CNT_W-1:0] cnt_q   [N_BTN];
  logic [CNT_W-1:0] cnt_d   [N_BTN];

  logic [N_BTN-1:0] dpb_q;
  logic [N_BTN-1:0] scen_q;
  logic [N_BTN-1:0] mcen_q;
  logic [N_BTN-1:0] ccen_q;

  // Moore decode packed as {dpb, scen, mcen, ccen}.
  function automatic logic [3:0] decode(input state_t s);
    logic [3:0] o;
    o = 4'b0000;
    case (s)
      SCEN_ST:      o = 4'b1111;
      HOLD:         o = 4'b1001;
      MCEN_ST:      o = 4'b1011;
      REPEAT:       o = 4'b1001;
      WAIT_RELEASE: o = 4'b1000;
      default:      o = 4'b0000;
    endcase
    return o;
  endfunction

  // Next-state logic; cnt is cleared on every state change so it can never wrap.
  always_comb begin
    for (int i = 0; i < N_BTN; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      case (state_q[i])
        IDLE: begin
          cnt_d[i] = '0;
          if (sync_p1[i]) state_d[i] = WAIT_PRESS;
        end
        WAIT_PRESS: begin
          if (!sync_p1[i]) begin
            state_d[i] = IDLE;
            cnt_d[i]   = '0;
          end else if (cnt_q[i] == DEB_LAST) begin
            state_d[i] = SCEN_ST;
            cnt_d[i]   = '0;
          end else begin
            cnt_d[i] = cnt_q[i] + 1'b1;
          end
        end
        SCEN_ST: begin
          state_d[i] = HOLD;
          cnt_d[i]   = '0;
        end
        HOLD: begin
          if (!sync_p1[i]) begin
            state_d[i] = WAIT_RELEASE;
            cnt_d[i]   = '0;
          end else if (cnt_q[i] == DLY_LAST) begin
            state_d[i] = MCEN_ST;
            cnt_d[i]   = '0;
          end else begin
            cnt_d[i] = cnt_q[i] + 1'b1;
          end
        end
        MCEN_ST: begin
          state_d[i] = sync_p1[i] ? REPEAT : WAIT_RELEASE;
          cnt_d[i]   = '0;
        end
        REPEAT: begin
          if (!sync_p1[i]) begin
            state_d[i] = WAIT_RELEASE;
            cnt_d[i]   = '0;
          end else if (cnt_q[i] == PER_LAST) begin
            state_d[i] = MCEN_ST;
            cnt_d[i]   = '0;
          end else begin
            cnt_d[i] = cnt_q[i] + 1'b1;
          end
        end
        WAIT_RELEASE: begin
          // A bounce back to 1 resumes the hold and restarts the repeat delay.
          if (sync_p1[i]) begin
            state_d[i] = HOLD;
            cnt_d[i]   = '0;
          end else if (cnt_q[i] == DEB_LAST) begin
            state_d[i] = IDLE;
            cnt_d[i]   = '0;
          end else begin
            cnt_d[i] = cnt_q[i] + 1'b1;
          end
        end
        default: begin
          state_d[i] = IDLE;
          cnt_d[i]   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
      dpb_q   <= '0;
      scen_q  <= '0;
      mcen_q  <= '0;
      ccen_q  <= '0;
      for (int i = 0; i < N_BTN; i++) begin
        state_q[i] <= IDLE;
        cnt_q[i]   <= '0;
      end
    end else begin
      // Stage p0 -> p1: metastability filter on the raw pins.
      sync_p0 <= bus.buttons;
      sync_p1 <= sync_p0;
      // FSM stage: state, counter and registered strobes.
      for (int i = 0; i < N_BTN; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
        {dpb_q[i], scen_q[i], mcen_q[i], ccen_q[i]} <= decode(state_d[i]);
      end
    end
  end

  assign bus.DPBs  = dpb_q;
  assign bus.SCENs = scen_q;
  assign bus.MCENs = mcen_q;
  assign bus.CCENs = ccen_q;

endmodule

// File: tb/tb_button_debouncer.sv
// Directed bench for button_debouncer with small timing parameters; expected SCEN/MCEN
// pulses are queued by the stimulus and matched by an independent monitor.
module tb_button_debouncer;

  logic clk;
  logic reset_n;
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;
  int   c0;

  typedef struct {
    int         cyc;
    logic [3:0] scen;
    logic [3:0] mcen;
  } ev_t;

  ev_t exp_q[$];
  ev_t ev;

  button_debouncer_if #(.N_BTN(4)) bus ();

  button_debouncer #(
    .N_BTN          (4),
    .DEBOUNCE_CYCLES(4),
    .MCEN_DELAY     (8),
    .MCEN_PERIOD    (3)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s at cyc %0d: got %0h, required %0h", name, cyc, act, req);
    end
  endtask

  task automatic push(input int t, input logic [3:0] s, input logic [3:0] m);
    ev_t e;
    e.cyc  = t;
    e.scen = s;
    e.mcen = m;
    exp_q.push_back(e);
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  // Pulse monitor: every SCEN/MCEN activity must match the next queued event.
  always @(negedge clk) begin
    if ((bus.SCENs | bus.MCENs) != 4'b0000) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL pulse_unexpected at cyc %0d: got scen=%b mcen=%b, required none",
                 cyc, bus.SCENs, bus.MCENs);
      end else begin
        ev = exp_q.pop_front();
        if (ev.cyc != cyc || ev.scen !== bus.SCENs || ev.mcen !== bus.MCENs) begin
          miscompares++;
          $display("FAIL pulse_match: got cyc=%0d scen=%b mcen=%b, required cyc=%0d scen=%b mcen=%b",
                   cyc, bus.SCENs, bus.MCENs, ev.cyc, ev.scen, ev.mcen);
        end
      end
    end
  end

  initial begin
    bus.buttons = 4'b0000;
    reset_n     = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_dpb",    bus.DPBs, 4'b0000);
    chk("reset_ccen",   bus.CCENs, 4'b0000);
    chk("reset_pulses", bus.SCENs | bus.MCENs, 4'b0000);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);

    // 1: clean press of btn0 held 12 edges, then released
    c0 = cyc;
    push(c0 + 7, 4'b0001, 4'b0001);
    bus.buttons[0] = 1'b1;
    wait_until(c0 + 6);  chk("t1_dpb_before", bus.DPBs, 4'b0000);
    wait_until(c0 + 7);  chk("t1_dpb_rise", bus.DPBs, 4'b0001);
                         chk("t1_ccen_rise", bus.CCENs, 4'b0001);
    wait_until(c0 + 12); bus.buttons[0] = 1'b0;
    wait_until(c0 + 14); chk("t1_ccen_hold", bus.CCENs, 4'b0001);
    wait_until(c0 + 15); chk("t1_ccen_drop", bus.CCENs, 4'b0000);
                         chk("t1_dpb_releasing", bus.DPBs, 4'b0001);
    wait_until(c0 + 18); chk("t1_dpb_late", bus.DPBs, 4'b0001);
    wait_until(c0 + 19); chk("t1_dpb_fall", bus.DPBs, 4'b0000);
    repeat (3) @(negedge clk);

    // 2: btn1 bounces during WAIT_PRESS, debounce restarts at the final rise
    c0 = cyc;
    push(c0 + 11, 4'b0010, 4'b0010);
    bus.buttons[1] = 1'b1;
    wait_until(c0 + 3);  bus.buttons[1] = 1'b0;
    wait_until(c0 + 4);  bus.buttons[1] = 1'b1;
    wait_until(c0 + 7);  chk("t2_no_early_dpb", bus.DPBs, 4'b0000);
    wait_until(c0 + 10); chk("t2_dpb_before", bus.DPBs, 4'b0000);
    wait_until(c0 + 11); chk("t2_dpb_rise", bus.DPBs, 4'b0010);
    wait_until(c0 + 12); bus.buttons[1] = 1'b0;
    wait_until(c0 + 19); chk("t2_dpb_fall", bus.DPBs, 4'b0000);
    repeat (3) @(negedge clk);

    // 3: btn2 held 40 edges, auto-repeat
    c0 = cyc;
    push(c0 + 7, 4'b0100, 4'b0100);
    for (int k = 16; k <= 40; k += 4) push(c0 + k, 4'b0000, 4'b0100);
    bus.buttons[2] = 1'b1;
    wait_until(c0 + 16); chk("t3_ccen_mcen", bus.CCENs, 4'b0100);
    wait_until(c0 + 18); chk("t3_ccen_repeat", bus.CCENs, 4'b0100);
    wait_until(c0 + 40); bus.buttons[2] = 1'b0;
                         chk("t3_ccen_last", bus.CCENs, 4'b0100);
    wait_until(c0 + 42); chk("t3_ccen_hold", bus.CCENs, 4'b0100);
    wait_until(c0 + 43); chk("t3_ccen_drop", bus.CCENs, 4'b0000);
                         chk("t3_dpb_releasing", bus.DPBs, 4'b0100);
    wait_until(c0 + 47); chk("t3_dpb_fall", bus.DPBs, 4'b0000);
    repeat (3) @(negedge clk);

    // 4a: plain release of btn3
    c0 = cyc;
    push(c0 + 7, 4'b1000, 4'b1000);
    bus.buttons[3] = 1'b1;
    wait_until(c0 + 9);  bus.buttons[3] = 1'b0;
    wait_until(c0 + 11); chk("t4_ccen_hold", bus.CCENs, 4'b1000);
    wait_until(c0 + 12); chk("t4_ccen_drop", bus.CCENs, 4'b0000);
                         chk("t4_dpb_releasing", bus.DPBs, 4'b1000);
    wait_until(c0 + 15); chk("t4_dpb_late", bus.DPBs, 4'b1000);
    wait_until(c0 + 16); chk("t4_dpb_fall", bus.DPBs, 4'b0000);
    repeat (3) @(negedge clk);

    // 4b: one-cycle re-press while btn3 is in WAIT_RELEASE
    c0 = cyc;
    push(c0 + 7, 4'b1000, 4'b1000);
    bus.buttons[3] = 1'b1;
    wait_until(c0 + 9);  bus.buttons[3] = 1'b0;
    wait_until(c0 + 12); bus.buttons[3] = 1'b1;
    wait_until(c0 + 13); bus.buttons[3] = 1'b0;
    wait_until(c0 + 15); chk("t4b_back_to_hold", bus.CCENs, 4'b1000);
    wait_until(c0 + 16); chk("t4b_ccen_drop", bus.CCENs, 4'b0000);
    wait_until(c0 + 19); chk("t4b_dpb_kept", bus.DPBs, 4'b1000);
    wait_until(c0 + 20); chk("t4b_dpb_fall", bus.DPBs, 4'b0000);
    repeat (3) @(negedge clk);

    // 5: asynchronous reset while btn0 is in REPEAT
    c0 = cyc;
    push(c0 + 7,  4'b0001, 4'b0001);
    push(c0 + 16, 4'b0000, 4'b0001);
    push(c0 + 27, 4'b0001, 4'b0001);
    bus.buttons[0] = 1'b1;
    wait_until(c0 + 18); chk("t5_in_repeat", bus.CCENs, 4'b0001);
    #2 reset_n = 1'b0;
    #1 chk("t5_async_dpb", bus.DPBs, 4'b0000);
       chk("t5_async_ccen", bus.CCENs, 4'b0000);
       chk("t5_async_pulses", bus.SCENs | bus.MCENs, 4'b0000);
    wait_until(c0 + 20); reset_n = 1'b1;
    wait_until(c0 + 26); chk("t5_redebounce", bus.DPBs, 4'b0000);
    wait_until(c0 + 27); chk("t5_dpb_rise", bus.DPBs, 4'b0001);
    wait_until(c0 + 28); bus.buttons[0] = 1'b0;
    wait_until(c0 + 35); chk("t5_dpb_fall", bus.DPBs, 4'b0000);
    repeat (3) @(negedge clk);

    // 6: all four together, btn0 released early
    c0 = cyc;
    push(c0 + 7,  4'b1111, 4'b1111);
    push(c0 + 16, 4'b0000, 4'b1111);
    push(c0 + 20, 4'b0000, 4'b1110);
    push(c0 + 24, 4'b0000, 4'b1110);
    push(c0 + 28, 4'b0000, 4'b1110);
    bus.buttons = 4'b1111;
    wait_until(c0 + 7);  chk("t6_dpb_all", bus.DPBs, 4'b1111);
    wait_until(c0 + 17); bus.buttons[0] = 1'b0;
    wait_until(c0 + 21); chk("t6_ccen_three", bus.CCENs, 4'b1110);
                         chk("t6_dpb_releasing", bus.DPBs, 4'b1111);
    wait_until(c0 + 24); chk("t6_dpb_three", bus.DPBs, 4'b1110);
    wait_until(c0 + 29); bus.buttons = 4'b0000;
    wait_until(c0 + 31); chk("t6_ccen_hold", bus.CCENs, 4'b1110);
    wait_until(c0 + 32); chk("t6_ccen_drop", bus.CCENs, 4'b0000);
    wait_until(c0 + 36); chk("t6_dpb_fall", bus.DPBs, 4'b0000);

    repeat (5) @(negedge clk);
    chk("pulses_outstanding", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
